// File: rtl/fight_pkg.sv
// Shared types and helpers for the fight_arena core.
// Action codes, FSM states, winner codes and width helpers.
package fight_pkg;

  typedef enum logic [2:0] {
    ACT_IDLE   = 3'd0,
    ACT_LEFT   = 3'd1,
    ACT_RIGHT  = 3'd2,
    ACT_ATTACK = 3'd3,
    ACT_DEFEND = 3'd4
  } action_t;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_FIGHT      = 2'd1,
    ST_ROUND_OVER = 2'd2,
    ST_MATCH_OVER = 2'd3
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;
  localparam logic [1:0] WIN_DRAW = 2'd3;

  function automatic int pos_w(input int cells);
    return (cells < 2) ? 1 : $clog2(cells);
  endfunction

  function automatic int life_w(input int lives);
    return $clog2(lives + 1);
  endfunction

endpackage

// File: rtl/fight_player.sv
// One player's position and lives registers.
// Reports its intended move and whether it is hit this tick.
module fight_player
  import fight_pkg::*;
#(
  parameter int ARENA_W = 8,
  parameter int LIVES   = 3,
  parameter int HOME    = 0,
  parameter int POS_W   = 3,
  parameter int LIFE_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              reload,
  input  logic [2:0]        action,
  input  logic [2:0]        opp_action,
  input  logic [POS_W-1:0]  opp_pos,
  input  logic              block,
  output logic [POS_W-1:0]  pos,
  output logic [LIFE_W-1:0] lives,
  output logic [POS_W-1:0]  target,
  output logic              moving,
  output logic              hit
);

  logic go_left;
  logic go_right;
  logic adjacent;

  assign go_left  = (action == ACT_LEFT) &&
                    (pos != '0);
  assign go_right = (action == ACT_RIGHT) &&
                    (pos != POS_W'(ARENA_W - 1));

  // Extended compare so the top cell never wraps onto cell 0.
  assign adjacent =
    ({1'b0, pos} + 1'b1 == {1'b0, opp_pos}) ||
    ({1'b0, opp_pos} + 1'b1 == {1'b0, pos});

  // Intended destination; wall and opponent-cell blocking.
  always_comb begin
    target = pos;
    unique case (1'b1)
      go_left:  target = pos - POS_W'(1);
      go_right: target = pos + POS_W'(1);
      default:  target = pos;
    endcase
    moving = (go_left || go_right) &&
             (target != opp_pos);
  end

  assign hit = (opp_action == ACT_ATTACK) &&
               (action != ACT_DEFEND) &&
               adjacent;

  // Position and lives update on qualified ticks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos   <= POS_W'(HOME);
      lives <= LIFE_W'(LIVES);
    end else if (reload) begin
      pos   <= POS_W'(HOME);
      lives <= LIFE_W'(LIVES);
    end else if (en) begin
      if (moving && !block)
        pos <= target;
      if (hit && lives != '0)
        lives <= lives - LIFE_W'(1);
    end
  end

endmodule

// File: rtl/fight_arena.sv
// Two-player fighting core: match/round FSM, wins, collisions.
// Optional round timer enabled by defining FIGHT_TIMER_EN.
module fight_arena
  import fight_pkg::*;
#(
  parameter int ARENA_W       = 8,
  parameter int LIVES         = 3,
  parameter int ROUNDS_TO_WIN = 2,
  parameter int ROUND_TICKS   = 64,
  localparam int POS_W  = pos_w(ARENA_W),
  localparam int LIFE_W = life_w(LIVES),
  localparam int WIN_W  = $clog2(ROUNDS_TO_WIN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               start,
  input  logic [2:0]         action1,
  input  logic [2:0]         action2,
  output logic [ARENA_W-1:0] place1,
  output logic [ARENA_W-1:0] place2,
  output logic [LIFE_W-1:0]  lives1,
  output logic [LIFE_W-1:0]  lives2,
  output logic [WIN_W-1:0]   wins1,
  output logic [WIN_W-1:0]   wins2,
  output logic [1:0]         state,
  output logic [1:0]         winner
);

  state_t             state_q, state_d;
  logic [WIN_W-1:0]   wins1_d, wins2_d;
  logic [1:0]         winner_d;
  logic               reload;
  logic               fight_tick;
  logic [POS_W-1:0]   pos1, pos2;
  logic [POS_W-1:0]   target1, target2;
  logic               moving1, moving2;
  logic               hit1, hit2;
  logic               collide;
  logic               ko1, ko2;
  logic               timeout;
  logic [1:0]         time_win;

  assign fight_tick = tick && (state_q == ST_FIGHT);
  assign collide    = moving1 && moving2 &&
                      (target1 == target2);
  assign ko1 = hit1 && (lives1 == LIFE_W'(1));
  assign ko2 = hit2 && (lives2 == LIFE_W'(1));

  fight_player #(
    .ARENA_W(ARENA_W), .LIVES(LIVES), .HOME(0),
    .POS_W(POS_W), .LIFE_W(LIFE_W)
  ) u_p1 (
    .clk(clk), .reset(reset),
    .en(fight_tick), .reload(reload),
    .action(action1), .opp_action(action2),
    .opp_pos(pos2), .block(collide),
    .pos(pos1), .lives(lives1),
    .target(target1), .moving(moving1), .hit(hit1)
  );

  fight_player #(
    .ARENA_W(ARENA_W), .LIVES(LIVES), .HOME(ARENA_W - 1),
    .POS_W(POS_W), .LIFE_W(LIFE_W)
  ) u_p2 (
    .clk(clk), .reset(reset),
    .en(fight_tick), .reload(reload),
    .action(action2), .opp_action(action1),
    .opp_pos(pos1), .block(collide),
    .pos(pos2), .lives(lives2),
    .target(target2), .moving(moving2), .hit(hit2)
  );

`ifdef FIGHT_TIMER_EN
  localparam int TMR_W = $clog2(ROUND_TICKS + 1);
  logic [TMR_W-1:0]  tmr_q;
  logic [LIFE_W-1:0] left1, left2;

  // Counts FIGHT ticks since the round began.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      tmr_q <= '0;
    else if (reload)
      tmr_q <= '0;
    else if (fight_tick)
      tmr_q <= tmr_q + TMR_W'(1);
  end

  assign timeout = fight_tick &&
                   (tmr_q == TMR_W'(ROUND_TICKS - 1));
  assign left1 = lives1 - LIFE_W'(hit1);
  assign left2 = lives2 - LIFE_W'(hit2);

  // Timeout verdict from post-tick lives.
  always_comb begin
    time_win = WIN_DRAW;
    if (left1 > left2)
      time_win = WIN_P1;
    else if (left2 > left1)
      time_win = WIN_P2;
  end
`else
  logic unused_ticks;
  assign unused_ticks = ^ROUND_TICKS;
  assign timeout  = 1'b0;
  assign time_win = WIN_NONE;
`endif

  // Match/round state and score registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      wins1   <= '0;
      wins2   <= '0;
      winner  <= WIN_NONE;
    end else begin
      state_q <= state_d;
      wins1   <= wins1_d;
      wins2   <= wins2_d;
      winner  <= winner_d;
    end
  end

  // Next-state, scoring and reload decisions.
  always_comb begin
    state_d  = state_q;
    wins1_d  = wins1;
    wins2_d  = wins2;
    winner_d = winner;
    reload   = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_MATCH_OVER: begin
        if (start) begin
          state_d  = ST_FIGHT;
          reload   = 1'b1;
          wins1_d  = '0;
          wins2_d  = '0;
          winner_d = WIN_NONE;
        end
      end
      ST_FIGHT: begin
        if (fight_tick) begin
          if (ko1 && ko2) begin
            state_d  = ST_ROUND_OVER;
            winner_d = WIN_DRAW;
          end else if (ko2) begin
            state_d  = ST_ROUND_OVER;
            winner_d = WIN_P1;
            wins1_d  = wins1 + WIN_W'(1);
          end else if (ko1) begin
            state_d  = ST_ROUND_OVER;
            winner_d = WIN_P2;
            wins2_d  = wins2 + WIN_W'(1);
          end else if (timeout) begin
            state_d  = ST_ROUND_OVER;
            winner_d = time_win;
            if (time_win == WIN_P1)
              wins1_d = wins1 + WIN_W'(1);
            else if (time_win == WIN_P2)
              wins2_d = wins2 + WIN_W'(1);
          end
        end
      end
      ST_ROUND_OVER: begin
        if (tick) begin
          if (wins1 == WIN_W'(ROUNDS_TO_WIN)) begin
            state_d  = ST_MATCH_OVER;
            winner_d = WIN_P1;
          end else if (wins2 == WIN_W'(ROUNDS_TO_WIN)) begin
            state_d  = ST_MATCH_OVER;
            winner_d = WIN_P2;
          end else begin
            state_d  = ST_FIGHT;
            reload   = 1'b1;
            winner_d = WIN_NONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign state  = state_q;
  assign place1 = {{(ARENA_W-1){1'b0}}, 1'b1} << pos1;
  assign place2 = {{(ARENA_W-1){1'b0}}, 1'b1} << pos2;

endmodule

// File: doc/fight_arena.md
# fight_arena

Parametrised two-player fighting-game core: it tracks both players' positions in an arena of configurable width, their lives, and their round wins across a best-of-N match. Player actions are resolved on a slow game tick. It sits between the action switches, the clock-divider tick, the position decoders and the lives display. Generalises the fixed 4-cell, single-round game with sizable arena, match/round FSM and an optional round timer.

## Interface
- ARENA_W, 8, number of arena cells (4..32); POS_W = $clog2(ARENA_W)
- LIVES, 3, lives per player per round (1..15); LIFE_W = $clog2(LIVES+1)
- ROUNDS_TO_WIN, 2, round wins needed to take the match (1..7); WIN_W = $clog2(ROUNDS_TO_WIN+1)
- ROUND_TICKS, 64, round length in ticks (used only with FIGHT_TIMER_EN)
- clk  in  1  system clock; single clock domain
- reset  in  1  asynchronous, active-low reset
- tick  in  1  one-clk-wide game-step strobe from the clock divider
- start  in  1  level; begins or restarts a match
- action1, action2  in  3  player action codes, sampled only on tick cycles
- place1, place2  out  ARENA_W  one-hot player positions
- lives1, lives2  out  LIFE_W  remaining lives
- wins1, wins2  out  WIN_W  rounds won
- state  out  2  FSM state: 0 IDLE, 1 FIGHT, 2 ROUND_OVER, 3 MATCH_OVER
- winner  out  2  0 none, 1 P1, 2 P2, 3 draw (last finished round or match)

## Operation
- Action codes: 0 IDLE, 1 LEFT, 2 RIGHT, 3 ATTACK, 4 DEFEND. Codes 5..7 are treated as IDLE.
- Reset values: pos1=0, pos2=ARENA_W-1, lives=LIVES, wins=0, state=IDLE, winner=0.
- IDLE: on start=1, go to FIGHT. Reload positions and lives, clear wins and winner.
- FIGHT, on each tick, resolution uses pre-tick positions:
  - Attack: if |pos1-pos2|==1 and the opponent's action is not DEFEND, the opponent loses 1 life. Lives saturate at 0. The attacker does not move.
  - Move: LEFT decrements, RIGHT increments. A move is blocked at cell 0, at cell ARENA_W-1, or onto the opponent's pre-tick cell.
  - If both players move into the same cell, both are blocked. Players never share a cell.
  - KO: if exactly one player reaches 0 lives, the other wins the round and that player's wins counter increments. If both reach 0 on the same tick, the round is a draw and no wins change. Either case goes to ROUND_OVER.
- ROUND_OVER: on the next tick:
  - If either wins counter equals ROUNDS_TO_WIN, go to MATCH_OVER and set winner to that player.
  - Otherwise go to FIGHT and reload positions and lives. winner holds until this transition.
- MATCH_OVER: all values freeze. On start=1, go to FIGHT as from IDLE.
- start is ignored in FIGHT and ROUND_OVER. Ticks are ignored in IDLE and MATCH_OVER.

## Timing
- All state is registered. Outputs change 1 clk after the tick cycle, so there is one update per tick.
- start acts on the clk edge where it is sampled high; it does not need a tick.
- tick and start in the same cycle while IDLE: start wins, and that tick is not resolved.
- Reset mid-match asynchronously forces all reset values and takes priority over everything.
- place outputs decode combinationally from the position registers. They show the reset pattern while reset is low.

## Configuration
- FIGHT_TIMER_EN defined:
  - A tick counter of width $clog2(ROUND_TICKS+1) clears on entry to FIGHT.
  - On the ROUND_TICKS-th FIGHT tick with no KO, the round ends: more lives wins, equal lives is a draw.
  - A KO on that same tick takes priority over the timeout.
- FIGHT_TIMER_EN undefined: no counter is built, and rounds end only by KO.

## Structure
- Package fight_pkg holds:
  - the action_t enum (codes above)
  - the state_t enum
  - winner encodings
  - POS_W/LIFE_W helper functions
- Sub-module fight_player, instantiated twice, holds one player's position and lives registers. Its inputs are the own action, the opponent's action and position, a tick qualifier, and reload. The top holds the FSM, wins counters, timer and the move-collision arbitration.

## Test plan
- Reset, then start, then 3 ticks with action1=RIGHT and action2=IDLE (ARENA_W=8) -> place1=8'b0000_1000, place2=8'b1000_0000, state=FIGHT.
- P1 at 3, P2 at 4, action1=ATTACK, action2=DEFEND on a tick -> lives2 stays 3. Same with action2=IDLE -> lives2=2.
- Players at 2 and 4, action1=RIGHT and action2=LEFT -> both blocked, positions remain 2 and 4.
- P2 KO'd twice with ROUNDS_TO_WIN=2 -> wins1=2, state=MATCH_OVER, winner=1. start then gives wins cleared, state=FIGHT.
- Mutual ATTACK when both players have lives=1 -> both 0, winner=3, wins unchanged, next tick FIGHT with lives=3.
- With FIGHT_TIMER_EN and ROUND_TICKS=4: lives 3 vs 2 after 4 ticks -> ROUND_OVER, winner=1. Reset asserted mid-round -> all outputs return to reset values immediately.
